// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector with saturating detection counter.
// Optional run-time pattern loading is enabled by defining SEQ_DET_PAT_LOAD_EN.
module seq_detector_param #(
  parameter int               PAT_W   = 3,
  parameter logic [PAT_W-1:0] PATTERN = 3'b011,
  parameter int               OVERLAP = 1,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inp_vld,
  input  logic             inp,
  input  logic             clr_cnt,
`ifdef SEQ_DET_PAT_LOAD_EN
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
`endif
  output logic             det,
  output logic [CNT_W-1:0] det_cnt
);

  localparam int             FW       = $clog2(PAT_W);
  localparam logic [FW-1:0]  FILL_MAX = FW'(PAT_W - 1);

  logic [PAT_W-2:0] r_hist;
  logic [FW-1:0]    r_fill;
  logic [CNT_W-1:0] r_cnt;
  logic [PAT_W-1:0] w_pat;
  logic [PAT_W-1:0] w_shift;
  logic             w_load;
  logic             w_match;

`ifdef SEQ_DET_PAT_LOAD_EN
  logic [PAT_W-1:0] r_pat;

  always_ff @(posedge clk) begin
    if (rst)
      r_pat <= PATTERN;
    else if (pat_load)
      r_pat <= pat_in;
  end

  assign w_pat  = r_pat;
  assign w_load = pat_load;
`else
  assign w_pat  = PATTERN;
  assign w_load = 1'b0;
`endif

  assign w_shift = {r_hist, inp};
  // Mealy match: the bit being presented completes the pattern this cycle.
  assign w_match = inp_vld & ~rst & ~w_load & (r_fill == FILL_MAX) & (w_shift == w_pat);
  assign det     = w_match;
  assign det_cnt = r_cnt;

  always_ff @(posedge clk) begin
    if (rst || w_load) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (inp_vld) begin
      if (w_match && (OVERLAP == 0)) begin
        r_hist <= '0;
        r_fill <= '0;
      end else begin
        r_hist <= w_shift[PAT_W-2:0];
        if (r_fill != FILL_MAX)
          r_fill <= r_fill + FW'(1);
      end
    end
  end

  // Clear wins over a same-cycle detect; the count never wraps.
  always_ff @(posedge clk) begin
    if (rst || clr_cnt)
      r_cnt <= '0;
    else if (w_match && (r_cnt != {CNT_W{1'b1}}))
      r_cnt <= r_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed self-checking bench for seq_detector_param across several parameter sets.
// Pattern-load scenarios run only when SEQ_DET_PAT_LOAD_EN is defined.
module tb_seq_detector_param;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic inp_vld = 1'b0;
  logic inp = 1'b0;
  logic clr_cnt = 1'b0;
  logic pat_load = 1'b0;
  logic [2:0] pat_in = 3'b000;
  logic [3:0] pat_in4 = 4'b0000;

  logic       det0, det1, det2, det3;
  logic [7:0] cnt0, cnt1, cnt2;
  logic [1:0] cnt3;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  seq_detector_param u0 (
    .clk(clk), .rst(rst), .inp_vld(inp_vld), .inp(inp), .clr_cnt(clr_cnt),
`ifdef SEQ_DET_PAT_LOAD_EN
    .pat_load(pat_load), .pat_in(pat_in),
`endif
    .det(det0), .det_cnt(cnt0));

  seq_detector_param #(.PAT_W(4), .PATTERN(4'b1010), .OVERLAP(1)) u1 (
    .clk(clk), .rst(rst), .inp_vld(inp_vld), .inp(inp), .clr_cnt(clr_cnt),
`ifdef SEQ_DET_PAT_LOAD_EN
    .pat_load(1'b0), .pat_in(pat_in4),
`endif
    .det(det1), .det_cnt(cnt1));

  seq_detector_param #(.PAT_W(4), .PATTERN(4'b1010), .OVERLAP(0)) u2 (
    .clk(clk), .rst(rst), .inp_vld(inp_vld), .inp(inp), .clr_cnt(clr_cnt),
`ifdef SEQ_DET_PAT_LOAD_EN
    .pat_load(1'b0), .pat_in(pat_in4),
`endif
    .det(det2), .det_cnt(cnt2));

  seq_detector_param #(.CNT_W(2)) u3 (
    .clk(clk), .rst(rst), .inp_vld(inp_vld), .inp(inp), .clr_cnt(clr_cnt),
`ifdef SEQ_DET_PAT_LOAD_EN
    .pat_load(1'b0), .pat_in(pat_in),
`endif
    .det(det3), .det_cnt(cnt3));

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic drive(input logic vld, input logic b, input logic r, input logic c);
    @(negedge clk);
    inp_vld = vld;
    inp     = b;
    rst     = r;
    clr_cnt = c;
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (det0 !== 1'b0) begin n_err++; $display("FAIL reset_det got=%b exp=0", det0); end
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (cnt0 !== 8'd0) begin n_err++; $display("FAIL reset_cnt0 got=%0d exp=0", cnt0); end
    n_checks++;
    if (cnt3 !== 2'd0) begin n_err++; $display("FAIL reset_cnt3 got=%0d exp=0", cnt3); end
  endtask

  task automatic test_basic();
    logic [5:0] bits;
    logic [5:0] exp;
    bits = 6'b011011;
    exp  = 6'b001001;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, bits[5-i], 1'b0, 1'b0);
      n_checks++;
      if (det0 !== exp[5-i]) begin
        n_err++; $display("FAIL basic_det bit=%0d got=%b exp=%b", i + 1, det0, exp[5-i]);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (cnt0 !== 8'd2) begin n_err++; $display("FAIL basic_cnt got=%0d exp=2", cnt0); end
  endtask

  task automatic test_overlap();
    logic [6:0] bits;
    logic [6:0] exp_ov;
    logic [6:0] exp_no;
    bits   = 7'b1010101;
    exp_ov = 7'b0001010;
    exp_no = 7'b0001000;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, bits[6-i], 1'b0, 1'b0);
      n_checks++;
      if (det1 !== exp_ov[6-i]) begin
        n_err++; $display("FAIL overlap_det bit=%0d got=%b exp=%b", i + 1, det1, exp_ov[6-i]);
      end
      n_checks++;
      if (det2 !== exp_no[6-i]) begin
        n_err++; $display("FAIL nonoverlap_det bit=%0d got=%b exp=%b", i + 1, det2, exp_no[6-i]);
      end
    end
  endtask

  task automatic test_gap();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (det0 !== 1'b0) begin n_err++; $display("FAIL gap_idle_det cyc=%0d got=%b exp=0", i, det0); end
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (det0 !== 1'b1) begin n_err++; $display("FAIL gap_det got=%b exp=1", det0); end
  endtask

  task automatic test_saturate();
    logic [1:0] exp_cnt [5];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (det3 !== 1'b1) begin n_err++; $display("FAIL sat_det round=%0d got=%b exp=1", k, det3); end
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (cnt3 !== exp_cnt[k]) begin
        n_err++; $display("FAIL sat_cnt round=%0d got=%0d exp=%0d", k, cnt3, exp_cnt[k]);
      end
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    n_checks++;
    if (det3 !== 1'b1) begin n_err++; $display("FAIL clr_det got=%b exp=1", det3); end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (cnt3 !== 2'd0) begin n_err++; $display("FAIL clr_cnt got=%0d exp=0", cnt3); end
  endtask

  task automatic test_rst_mid();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (det0 !== 1'b0) begin n_err++; $display("FAIL rst_forced_det got=%b exp=0", det0); end
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (det0 !== 1'b0) begin n_err++; $display("FAIL rst_mid_det got=%b exp=0", det0); end
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (det0 !== 1'b0) begin n_err++; $display("FAIL rst_mid_early got=%b exp=0", det0); end
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (det0 !== 1'b1) begin n_err++; $display("FAIL rst_mid_after got=%b exp=1", det0); end
  endtask

`ifdef SEQ_DET_PAT_LOAD_EN
  task automatic test_pat_load();
    logic [3:0] bits;
    logic [3:0] exp;
    bits = 4'b1110;
    exp  = 4'b0001;
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    pat_in   = 3'b110;
    pat_load = 1'b1;
    inp_vld  = 1'b1;
    inp      = 1'b1;
    #1;
    n_checks++;
    if (det0 !== 1'b0) begin n_err++; $display("FAIL load_cycle_det got=%b exp=0", det0); end
    @(negedge clk);
    pat_load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, bits[3-i], 1'b0, 1'b0);
      n_checks++;
      if (det0 !== exp[3-i]) begin
        n_err++; $display("FAIL load_det bit=%0d got=%b exp=%b", i + 1, det0, exp[3-i]);
      end
    end
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (det0 !== 1'b1) begin n_err++; $display("FAIL load_reset_default got=%b exp=1", det0); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_overlap();
    test_gap();
    test_saturate();
    test_rst_mid();
`ifdef SEQ_DET_PAT_LOAD_EN
    test_pat_load();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial pattern detector: the general-purpose successor to the team's fixed three-bit Mealy detectors. Matches a PAT_W-bit pattern on a qualified serial bit stream, with overlapping or non-overlapping detection, and counts detections in a saturating counter. It sits on a serial input path, after the bit synchroniser, and drives single-cycle detect strobes to downstream control logic.

## Interface
- PAT_W, 3: pattern length in bits; legal range 2..16.
- PATTERN, 3'b011: reset and default pattern; the MSB is the oldest bit received.
- OVERLAP, 1: 1 = overlapping detection, 0 = non-overlapping.
- CNT_W, 8: width of the detection counter.
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- inp_vld  input  1  qualifies `inp`; a bit is accepted only when this is 1.
- inp  input  1  serial data bit.
- clr_cnt  input  1  synchronous clear of `det_cnt`.
- det  output  1  Mealy detect strobe, combinational from `inp`/`inp_vld` and the registered state.
- det_cnt  output  CNT_W  registered, saturating detection count.
- pat_load  input  1  present only with SEQ_DET_PAT_LOAD_EN; loads a new pattern.
- pat_in  input  PAT_W  present only with SEQ_DET_PAT_LOAD_EN; the pattern value to load.

## Operation
- State registers:
  - `hist`: PAT_W-1 bits, the most recently accepted bits.
  - `fill`: 0..PAT_W-1, the number of valid history bits, saturating at PAT_W-1.
  - `pat`: PAT_W bits, the active pattern.
  - `det_cnt`.
- Match condition: `det = inp_vld & (fill == PAT_W-1) & ({hist, inp} == pat)`. `det` is forced to 0 while `rst` is 1, and also while `pat_load` is 1 when the macro is defined.
- Accepted bit, normal case: `hist` shifts left with `inp` entering at the LSB; `fill` increments, saturating at PAT_W-1.
- Accepted bit with `det` = 1 and OVERLAP = 0: `hist` is cleared to 0 and `fill` is cleared to 0. Detection restarts from scratch.
- Accepted bit with `det` = 1 and OVERLAP = 1: normal shift. The matched tail can contribute to the next match.
- `inp_vld` = 0: all of `hist`, `fill` and `pat` hold; `det` = 0. Gaps of any length do not break a partial match.
- `det_cnt` update rules:
  - `clr_cnt` = 1: `det_cnt` goes to 0. This has priority over a same-cycle detect, so that detect is not counted.
  - Otherwise, when `det` = 1 and `det_cnt` is not all-ones, `det_cnt` increments by 1.
  - At all-ones, `det_cnt` holds (saturates); it never wraps.
- Reset values: `hist` = 0, `fill` = 0, `pat` = PATTERN, `det_cnt` = 0, `det` = 0.
- Reset asserted mid-stream discards any partial match. The first detect after reset requires PAT_W fresh accepted bits.

## Timing
- `det` is asserted in the same cycle that the final pattern bit is presented with `inp_vld` = 1, giving zero-cycle latency. It is valid only for that cycle.
- `det_cnt` reflects a detect one cycle after `det`, i.e. after the next rising edge.
- Minimum spacing between detects:
  - OVERLAP = 1: back-to-back detects are possible. For example, pattern 11 on the stream 111 gives detects on bits 2 and 3.
  - OVERLAP = 0: a detect requires at least PAT_W accepted bits after the previous detect.
- `clr_cnt` takes effect at the next edge; `det_cnt` reads 0 the following cycle.

## Configuration
- Macro: SEQ_DET_PAT_LOAD_EN.
- Defined:
  - The `pat_load` and `pat_in` ports exist.
  - When `pat_load` = 1: `pat` <= `pat_in`; `hist` and `fill` are cleared to 0; any `inp` in that cycle is discarded; `det` = 0 in that cycle.
  - `rst` has priority over `pat_load`.
- Not defined:
  - The ports are absent.
  - `pat` is the constant PATTERN; no pattern register is inferred.

## Test plan
- Default parameters, 0-1-1-0-1-1 with `inp_vld` = 1 → `det` = 1 on bits 3 and 6 only; `det_cnt` = 2.
- PATTERN = 4'b1010, stream 1010101:
  - OVERLAP = 1 → `det` on bits 4 and 6.
  - OVERLAP = 0 → `det` on bit 4 only.
- Pattern 011, stream 0,1 then 5 cycles of `inp_vld` = 0, then 1 → `det` = 1 on that last valid cycle.
- CNT_W = 2, five detects → `det_cnt` sequence 1, 2, 3, 3, 3. Then `clr_cnt` asserted in the same cycle as a detect → `det_cnt` = 0, not 1.
- Stream 0,1, then `rst` pulsed, then 1 → no detect. The next stream 0,1,1 → detect on its third bit.
- SEQ_DET_PAT_LOAD_EN defined:
  - Load 3'b110 after stream 0,1 → the next bit 1 gives no detect.
  - A subsequent 1,1,0 → detect on the 0.
  - After reset, `pat` reads back as the default 011.
